// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data stages, one access in flight at a time.
// Grant is same-cycle, read data returns MEM_LAT+1 cycles after grant; requesters hold req/payload until gnt.
module mem_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              own_dm;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     starve_cnt;

  logic last_wait;
  logic grantable;
  logic if_win;
  logic if_outstanding;
  logic dm_outstanding;

  always_comb begin
    last_wait      = (state == WAIT) && (cnt == 4'd1);
    // reset gating keeps every output quiet while reset is held low
    grantable      = reset && ((state == IDLE) || last_wait);
    if_win         = if_req && (!dm_req || (starve_cnt == SW'(STARVE_MAX)));
    if_gnt         = grantable && if_win;
    dm_gnt         = grantable && dm_req && !if_win;

    if_rvalid      = last_wait && !own_dm;
    dm_rvalid      = last_wait && own_dm;
    if_rdata       = if_rvalid ? mem_rdata : '0;
    dm_rdata       = (dm_rvalid && !we_q) ? mem_rdata : '0;

    mem_en         = (state == ISSUE);
    mem_we         = mem_en && we_q;
    mem_addr       = mem_en ? addr_q : '0;
    mem_wdata      = mem_en ? wdata_q : '0;

    if_outstanding = (state != IDLE) && !own_dm;
    dm_outstanding = (state != IDLE) && own_dm;
    stall_if       = reset && (if_req || if_outstanding) && !if_rvalid;
    stall_mem      = reset && (dm_req || dm_outstanding) && !dm_rvalid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      own_dm     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      if (if_gnt || dm_gnt) begin
        state   <= ISSUE;
        own_dm  <= dm_gnt;
        we_q    <= dm_gnt && dm_we;
        addr_q  <= dm_gnt ? dm_addr : if_addr;
        wdata_q <= dm_gnt ? dm_wdata : '0;
      end else if (state == ISSUE) begin
        state <= WAIT;
        cnt   <= 4'(MEM_LAT);
      end else if (state == WAIT) begin
        if (cnt == 4'd1) state <= IDLE;
        else             cnt   <= cnt - 4'd1;
      end

      // fetch only counts as starved while it keeps asking and data keeps winning
      if (!if_req || if_gnt)
        starve_cnt <= '0;
      else if (dm_gnt && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule
